// File: rtl/ea_calc_pkg.sv
// Shared CPU definitions used by the effective-address calculator:
// instruction field positions (PDP-10 bit numbering, bit 0 = MSB),
// the address width, and the ea_calc state encoding.
package ea_calc_pkg;

  // 18-bit PDP-10 address width
  localparam int AW = 18;

  // Instruction word fields, numbered 0 (MSB) .. 35 (LSB)
  localparam int I_BIT   = 13;
  localparam int X_FIRST = 14;
  localparam int X_LAST  = 17;
  localparam int Y_FIRST = 18;
  localparam int Y_LAST  = 35;

  // Effective-address calculator states
  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_CALC = 2'd1,
    S_READ = 2'd2,
    S_DONE = 2'd3
  } ea_state_t;

endpackage

// File: rtl/ea_calc.sv
// Effective-address calculator: resolves E = Y + C(X)[18:35], following
// indirect words while I = 1, and strobes the 18-bit result out once.
module ea_calc
  import ea_calc_pkg::*;
#(
  parameter int CNTW = 8
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             start,
  input  logic             abort,
  input  logic [0:35]      dbus,
  output logic [0:3]       xaddr,
  input  logic [0:35]      xdata,
  output logic             memreq,
  output logic [18:35]     memaddr,
  input  logic             memack,
  input  logic [0:35]      memdata,
  output logic [18:35]     ea,
  output logic             eavalid,
  output logic             busy,
  output logic [0:CNTW-1]  nind
);

  ea_state_t         state;
  ea_state_t         state_next;

  // Latched instruction / indirect-word fields
  logic              i_reg;
  logic [3:0]        x_reg;
  logic [AW-1:0]     y_reg;

  logic [AW-1:0]     index_val;
  logic [AW-1:0]     sum;

  // The AC file is read straight from the latched index field
  assign xaddr = x_reg;

  // AC0 is never an index register; the carry out of bit 18 is dropped
  assign index_val = (x_reg != 4'd0) ? xdata[Y_FIRST:Y_LAST] : '0;
  assign sum       = y_reg + index_val;

  // State register
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state <= S_IDLE;
    end else begin
      state <= state_next;
    end
  end

  // Next-state logic; abort overrides every other transition
  always_comb begin
    state_next = state;
    case (state)
      S_IDLE:  if (start) state_next = S_CALC;
      S_CALC:  state_next = i_reg ? S_READ : S_DONE;
      S_READ:  if (memack) state_next = S_CALC;
      S_DONE:  state_next = S_IDLE;
      default: state_next = S_IDLE;
    endcase
    if (abort) begin
      state_next = S_IDLE;
    end
  end

  // Datapath and registered outputs
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      i_reg   <= 1'b0;
      x_reg   <= 4'd0;
      y_reg   <= '0;
      ea      <= '0;
      eavalid <= 1'b0;
      busy    <= 1'b0;
      memreq  <= 1'b0;
      memaddr <= '0;
      nind    <= '0;
    end else begin
      eavalid <= 1'b0;
      busy    <= (state_next != S_IDLE);
      case (state)
        S_IDLE: begin
          if (start && !abort) begin
            i_reg <= dbus[I_BIT];
            x_reg <= dbus[X_FIRST:X_LAST];
            y_reg <= dbus[Y_FIRST:Y_LAST];
            nind  <= '0;
          end
        end
        S_CALC: begin
          if (!abort) begin
            if (i_reg) begin
              memaddr <= sum;
              memreq  <= 1'b1;
            end else begin
              ea      <= sum;
              eavalid <= 1'b1;
            end
          end
        end
        S_READ: begin
          if (abort) begin
            // memdata arriving with abort is discarded
            memreq <= 1'b0;
          end else if (memack) begin
            memreq <= 1'b0;
            i_reg  <= memdata[I_BIT];
            x_reg  <= memdata[X_FIRST:X_LAST];
            y_reg  <= memdata[Y_FIRST:Y_LAST];
            if (nind != {CNTW{1'b1}}) begin
              nind <= nind + CNTW'(1);
            end
          end
        end
        default: begin
          memreq <= 1'b0;
        end
      endcase
    end
  end

endmodule
